// File: rtl/pbit_state_tally.sv
// Tallies ones per p-bit over a power-of-two window after an optional burn-in.
// Reports per-bit counts and a strict-majority vector with a one-cycle done pulse.
module pbit_state_tally #(
    parameter int N_BITS       = 5,
    parameter int BURN_IN      = 16,
    parameter int LOG2_SAMPLES = 10
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  sample_en,
    input  logic [N_BITS-1:0]                     p_bits,
    output logic                                  busy,
    output logic                                  done,
    output logic [N_BITS*(LOG2_SAMPLES+1)-1:0]    counts,
    output logic [N_BITS-1:0]                     majority
);

    localparam int CNT_W  = LOG2_SAMPLES + 1;
    localparam int BURN_W = (BURN_IN > 1) ? $clog2(BURN_IN) : 1;

    localparam logic [BURN_W-1:0] BURN_LAST = BURN_W'((BURN_IN > 0) ? (BURN_IN - 1) : 0);
    localparam logic [CNT_W-1:0]  SMP_LAST  = CNT_W'((2 ** LOG2_SAMPLES) - 1);
    localparam logic [CNT_W-1:0]  HALF      = CNT_W'(2 ** (LOG2_SAMPLES - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURN,
        S_SAMPLE,
        S_REPORT
    } state_t;

    state_t                      state_q;
    logic [BURN_W-1:0]           burn_cnt_q;
    logic [CNT_W-1:0]            smp_cnt_q;
    logic [CNT_W-1:0]            acc_q [N_BITS];
    logic [CNT_W-1:0]            acc_d [N_BITS];
    logic [N_BITS*CNT_W-1:0]     counts_q;
    logic [N_BITS*CNT_W-1:0]     counts_d;
    logic [N_BITS-1:0]           maj_q;
    logic [N_BITS-1:0]           maj_d;
    logic                        busy_q;
    logic                        done_q;
    logic                        last_smp;

    assign last_smp = (smp_cnt_q == SMP_LAST);

    // Accumulators with the current sample folded in; on the final sample these
    // are the results, so counts/majority can be registered on that same edge.
    always_comb begin
        for (int i = 0; i < N_BITS; i++) begin
            acc_d[i]                    = acc_q[i] + CNT_W'(p_bits[i]);
            counts_d[i*CNT_W +: CNT_W]  = acc_d[i];
            maj_d[i]                    = (acc_d[i] > HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            counts_q   <= '0;
            maj_q      <= '0;
            burn_cnt_q <= '0;
            smp_cnt_q  <= '0;
            for (int i = 0; i < N_BITS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        burn_cnt_q <= '0;
                        smp_cnt_q  <= '0;
                        for (int i = 0; i < N_BITS; i++) begin
                            acc_q[i] <= '0;
                        end
                        busy_q  <= 1'b1;
                        state_q <= (BURN_IN == 0) ? S_SAMPLE : S_BURN;
                    end
                end
                S_BURN: begin
                    if (sample_en) begin
                        if (burn_cnt_q == BURN_LAST) begin
                            state_q <= S_SAMPLE;
                        end else begin
                            burn_cnt_q <= burn_cnt_q + BURN_W'(1);
                        end
                    end
                end
                S_SAMPLE: begin
                    if (sample_en) begin
                        for (int i = 0; i < N_BITS; i++) begin
                            acc_q[i] <= acc_d[i];
                        end
                        smp_cnt_q <= smp_cnt_q + CNT_W'(1);
                        if (last_smp) begin
                            state_q  <= S_REPORT;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            counts_q <= counts_d;
                            maj_q    <= maj_d;
                        end
                    end
                end
                S_REPORT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign counts   = counts_q;
    assign majority = maj_q;

endmodule

// File: tb/tb_pbit_state_tally.sv
// Directed bench for pbit_state_tally: table of tallies on two configurations
// (BURN_IN=2 and BURN_IN=0, window 8) plus restart-ignore and mid-run reset.
module tb_pbit_state_tally;

    localparam int NB  = 5;
    localparam int L2  = 3;
    localparam int CW  = NB * (L2 + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start_a, start_b;
    logic          sample_en;
    logic [NB-1:0] p_bits;
    logic          busy_a, done_a, busy_b, done_b;
    logic [CW-1:0] counts_a, counts_b;
    logic [NB-1:0] maj_a, maj_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pbit_state_tally #(.N_BITS(NB), .BURN_IN(2), .LOG2_SAMPLES(L2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sample_en(sample_en), .p_bits(p_bits),
        .busy(busy_a), .done(done_a), .counts(counts_a), .majority(maj_a)
    );

    pbit_state_tally #(.N_BITS(NB), .BURN_IN(0), .LOG2_SAMPLES(L2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sample_en(sample_en), .p_bits(p_bits),
        .busy(busy_b), .done(done_b), .counts(counts_b), .majority(maj_b)
    );

    typedef struct {
        bit            sel;      // 0 = dut_a (BURN_IN=2), 1 = dut_b (BURN_IN=0)
        int            burn;
        int            mode;     // 0 constant, 1 alternate 11111/00000, 2 pat for 5 samples then 0
        bit            toggle;   // sample_en 1,0,1,0...
        logic [NB-1:0] pat;
        logic [CW-1:0] exp_cnt;
        logic [NB-1:0] exp_maj;
        int            exp_done;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [CW-1:0] pack5(input logic [3:0] c4, input logic [3:0] c3,
                                            input logic [3:0] c2, input logic [3:0] c1,
                                            input logic [3:0] c0);
        return {c4, c3, c2, c1, c0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] value_for(input vec_t v, input int sidx);
        case (v.mode)
            1:       return (sidx % 2 == 0) ? 5'b11111 : 5'b00000;
            2:       return (sidx < 5) ? v.pat : 5'b00000;
            default: return v.pat;
        endcase
    endfunction

    task automatic run_rec(input int r, input bit repulse, input bit hold_chk,
                           input logic [CW-1:0] hold_cnt);
        vec_t          v;
        int            q;
        int            j;
        int            busy_n;
        int            done_j;
        bit            en;
        logic [CW-1:0] c_obs;
        logic [NB-1:0] m_obs;
        logic          b_obs, d_obs;
        v      = tbl[r];
        q      = 0;
        busy_n = 0;
        done_j = -1;
        c_obs  = '0;
        m_obs  = '0;
        @(negedge clk);
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
        sample_en = 1'b1;
        p_bits    = ~v.pat;
        @(negedge clk);
        j = 1;
        while (j <= 60 && done_j < 0) begin
            b_obs = v.sel ? busy_b : busy_a;
            d_obs = v.sel ? done_b : done_a;
            if (d_obs) begin
                done_j = j;
                c_obs  = v.sel ? counts_b : counts_a;
                m_obs  = v.sel ? maj_b : maj_a;
            end
            if (b_obs) busy_n++;
            if (hold_chk && j == 5) chk($sformatf("hold_counts_r%0d", r), 32'(counts_a), 32'(hold_cnt));
            start_a = (repulse && !v.sel && j == 5);
            start_b = (repulse &&  v.sel && j == 5);
            en = v.toggle ? (j % 2 == 1) : 1'b1;
            sample_en = en;
            if (en) begin
                p_bits = (q < v.burn) ? ~v.pat : value_for(v, q - v.burn);
                q++;
            end else begin
                p_bits = ~v.pat;
            end
            if (done_j < 0) begin
                @(negedge clk);
                j++;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk($sformatf("done_cycle_r%0d", r), 32'(done_j), 32'(v.exp_done));
        chk($sformatf("busy_cycles_r%0d", r), 32'(busy_n), 32'(v.exp_done - 1));
        chk($sformatf("counts_r%0d", r), 32'(c_obs), 32'(v.exp_cnt));
        chk($sformatf("majority_r%0d", r), 32'(m_obs), 32'(v.exp_maj));
        @(negedge clk);
        chk($sformatf("done_pulse_r%0d", r), 32'({busy_a, done_a, busy_b, done_b}), 32'(0));
    endtask

    initial begin
        tbl[0] = '{0, 2, 0, 0, 5'b10110, pack5(8, 0, 8, 8, 0), 5'b10110, 11};
        tbl[1] = '{0, 2, 1, 0, 5'b11111, pack5(4, 4, 4, 4, 4), 5'b00000, 11};
        tbl[2] = '{0, 2, 0, 1, 5'b00001, pack5(0, 0, 0, 0, 8), 5'b00001, 20};
        tbl[3] = '{1, 0, 0, 0, 5'b00011, pack5(0, 0, 0, 8, 8), 5'b00011, 9};
        tbl[4] = '{0, 2, 2, 0, 5'b01010, pack5(0, 5, 0, 5, 0), 5'b01010, 11};

        reset     = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        sample_en = 1'b0;
        p_bits    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy_done", 32'({busy_a, done_a, busy_b, done_b}), 32'(0));
        chk("reset_counts_a", 32'(counts_a), 32'(0));
        chk("reset_counts_b", 32'(counts_b), 32'(0));
        chk("reset_majority", 32'({maj_a, maj_b}), 32'(0));

        for (int r = 0; r < 5; r++) begin
            run_rec(r, 1'b0, 1'b0, '0);
        end

        // start during SAMPLE is ignored; results then hold through the next run
        run_rec(0, 1'b1, 1'b0, '0);
        begin
            int extra;
            extra = 0;
            repeat (4) begin
                @(negedge clk);
                if (done_a || busy_a) extra++;
            end
            chk("no_restart_after_repulse", 32'(extra), 32'(0));
        end
        run_rec(4, 1'b0, 1'b1, tbl[0].exp_cnt);

        // reset in the middle of SAMPLE aborts and zeroes outputs
        @(negedge clk);
        start_a   = 1'b1;
        sample_en = 1'b1;
        p_bits    = 5'b11111;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_mid_sample", 32'(busy_a), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy_done", 32'({busy_a, done_a}), 32'(0));
        chk("abort_counts", 32'(counts_a), 32'(0));
        chk("abort_majority", 32'(maj_a), 32'(0));
        begin
            int extra;
            extra = 0;
            repeat (15) begin
                @(negedge clk);
                if (done_a || busy_a) extra++;
            end
            chk("no_done_after_abort", 32'(extra), 32'(0));
        end
        run_rec(0, 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pbit_state_tally.md
Name: pbit_state_tally

Overview:
- Downstream consumer of an invertible p-bit gate's `p_bits` vector, e.g. the 5-bit a,b,cin,s,cout output of the full-adder gate.
- On a start command it discards a burn-in period, then counts ones per bit over a power-of-two sample window.
- It then reports per-bit counts and a majority vector with a one-cycle done pulse.
- Replaces bench-side averaging loops so clamped-mode results can be read by hardware, e.g. a ripple-adder controller or a readout register.

Parameters:
- N_BITS, 5, width of the sampled p-bit vector.
- BURN_IN, 16, number of qualified cycles discarded before sampling. 0 is legal.
- LOG2_SAMPLES, 10, log2 of the sample window size (window = 2^LOG2_SAMPLES qualified samples). Legal range 1..20.
- Derived localparam CNT_W = LOG2_SAMPLES+1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a tally. Honoured only in IDLE.
- sample_en  input  1  qualifies a cycle for burn-in counting and sampling. Tie high to sample every cycle, or drive from the update sequencer's end-of-sweep strobe.
- p_bits  input  N_BITS  p-bit states to tally.
- busy  output  1  high in BURN and SAMPLE.
- done  output  1  one-cycle pulse when results update.
- counts  output  N_BITS*CNT_W  ones-count for bit i in field [i*CNT_W +: CNT_W].
- majority  output  N_BITS  bit i = 1 iff count_i > 2^(LOG2_SAMPLES-1). An exact half reports 0.

Behaviour:
- States: IDLE, BURN, SAMPLE, REPORT.
- Reset (synchronous, takes priority over everything):
  - state goes to IDLE.
  - busy=0, done=0, counts=0, majority=0.
  - Internal burn counter, sample counter and accumulators are cleared.
- IDLE:
  - start=1 clears the accumulators and burn/sample counters.
  - Next state is BURN, or SAMPLE directly if BURN_IN=0.
  - start=0 keeps IDLE.
- BURN:
  - Each sample_en=1 cycle increments the burn counter; p_bits is ignored.
  - When the BURN_IN-th qualified cycle is seen, the next state is SAMPLE.
  - sample_en=0 cycles neither count nor advance.
- SAMPLE:
  - Each sample_en=1 cycle adds p_bits[i] to accumulator i and increments the sample counter.
  - On the 2^LOG2_SAMPLES-th qualified sample, that sample is included and the next state is REPORT.
  - The sample counter has LOG2_SAMPLES+1 bits. Accumulators are CNT_W bits and never overflow (max value 2^LOG2_SAMPLES).
- REPORT (exactly one cycle):
  - done=1.
  - counts and majority outputs are registered from the final accumulators; they are valid in the same cycle as done.
  - Next state is IDLE.
- Output hold: counts and majority hold their values until the next REPORT or reset. They are not cleared by a new start.
- start while busy or in REPORT is ignored, with no restart.
- Latency with sample_en held high: if start is sampled at edge k, busy is high from cycle k+1, and done is high in cycle k+1+BURN_IN+2^LOG2_SAMPLES.
- busy is low in REPORT and IDLE.
- Reset mid-BURN or mid-SAMPLE aborts the tally; no done is produced and outputs are zeroed.
- p_bits is sampled synchronously with no metastability handling; the source is same-clock.

Test Plan:
1. N_BITS=5, BURN_IN=2, LOG2_SAMPLES=3, sample_en=1, p_bits=5'b10110 constant, pulse start → busy for 10 cycles; done in cycle k+11; counts = {8,0,8,8,0} (bit4..bit0); majority=5'b10110.
2. Same config, p_bits alternating 5'b11111/5'b00000 every qualified cycle, starting with 11111 in the first SAMPLE cycle → every count = 4; majority=5'b00000 (tie rule).
3. sample_en toggling 1,0,1,0… with p_bits=5'b00001 on enabled cycles and 5'b11110 on disabled cycles → count0=8, all others 0; done arrives 2x later than scenario 1 (±1 cycle for phase).
4. BURN_IN=0, LOG2_SAMPLES=3, p_bits=5'b00011 → SAMPLE entered the cycle after start; done in cycle k+9; counts bits0,1 = 8.
5. start re-pulsed during SAMPLE, then after done → the first tally completes unperturbed with a single done; the second tally starts only from the post-done start; outputs from the first run hold until the second done.
6. reset asserted for 1 cycle mid-SAMPLE → next cycle busy=0, counts=0, majority=0, no done pulse; a subsequent start produces a correct full tally.
